dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin data-memory arbiter (optional DMEM_ALIGN_CHECK_EN alignment reject)
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_rw,
    input  logic [1:0]        a_size,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_req,
    input  logic              b_rw,
    input  logic [1:0]        b_size,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_done,
    output logic              b_done,
    output logic              a_err,
    output logic              b_err,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_enable,
    output logic              ram_rw,
    output logic [1:0]        ram_size,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              gnt_b_q, gnt_b_d;
    logic              rej_q, rej_d;
    logic              cmd_rw_q, cmd_rw_d;
    logic [1:0]        cmd_size_q, cmd_size_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_din_q, cmd_din_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              pick_b;
    logic              sel_rw;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              reject;

    // On contention the port that did not win last time is granted.
    assign pick_b    = b_req && (!a_req || !gnt_b_q);
    assign sel_rw    = pick_b ? b_rw    : a_rw;
    assign sel_size  = pick_b ? b_size  : a_size;
    assign sel_addr  = pick_b ? b_addr  : a_addr;
    assign sel_wdata = pick_b ? b_wdata : a_wdata;

`ifdef DMEM_ALIGN_CHECK_EN
    assign reject = (sel_size == 2'b11) ||
                    (sel_size == 2'b01 && sel_addr[0]) ||
                    (sel_size == 2'b10 && sel_addr[1:0] != 2'b00);
`else
    assign reject = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        gnt_b_d    = gnt_b_q;
        rej_d      = rej_q;
        cmd_rw_d   = cmd_rw_q;
        cmd_size_d = cmd_size_q;
        cmd_addr_d = cmd_addr_q;
        cmd_din_d  = cmd_din_q;
        rdata_d    = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (a_req || b_req) begin
                    gnt_b_d = pick_b;
                    rej_d   = reject;
                    if (reject) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_ACCESS;
                        cmd_rw_d   = sel_rw;
                        cmd_size_d = sel_size;
                        cmd_addr_d = sel_addr;
                        cmd_din_d  = sel_wdata;
                    end
                end
            end
            S_ACCESS: begin
                if (!cmd_rw_q) begin
                    rdata_d = ram_dout;
                end
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            gnt_b_q    <= 1'b1;
            rej_q      <= 1'b0;
            cmd_rw_q   <= 1'b0;
            cmd_size_q <= 2'b00;
            cmd_addr_q <= '0;
            cmd_din_q  <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            gnt_b_q    <= gnt_b_d;
            rej_q      <= rej_d;
            cmd_rw_q   <= cmd_rw_d;
            cmd_size_q <= cmd_size_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_din_q  <= cmd_din_d;
            rdata_q    <= rdata_d;
        end
    end

    // Outputs decode straight from state so an asynchronous reset clears them at once.
    assign ram_enable = (state_q == S_ACCESS);
    assign ram_rw     = ram_enable && cmd_rw_q;
    assign ram_size   = cmd_size_q;
    assign ram_addr   = cmd_addr_q;
    assign ram_din    = cmd_din_q;
    assign rdata      = rdata_q;

    assign a_done = (state_q == S_DONE) && !gnt_b_q && !rej_q;
    assign b_done = (state_q == S_DONE) &&  gnt_b_q && !rej_q;
`ifdef DMEM_ALIGN_CHECK_EN
    assign a_err  = (state_q == S_DONE) && !gnt_b_q &&  rej_q;
    assign b_err  = (state_q == S_DONE) &&  gnt_b_q &&  rej_q;
`else
    assign a_err  = 1'b0;
    assign b_err  = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - vector table plus scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_req = 1'b0, a_rw = 1'b0;
    logic [1:0]  a_size = 2'b00;
    logic [7:0]  a_addr = 8'h00;
    logic [31:0] a_wdata = 32'h0;
    logic        b_req = 1'b0, b_rw = 1'b0;
    logic [1:0]  b_size = 2'b00;
    logic [7:0]  b_addr = 8'h00;
    logic [31:0] b_wdata = 32'h0;
    logic        a_done, b_done, a_err, b_err;
    logic [31:0] rdata;
    logic        ram_enable, ram_rw;
    logic [1:0]  ram_size;
    logic [7:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_rw(a_rw), .a_size(a_size), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_rw(b_rw), .b_size(b_size), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_done(a_done), .b_done(b_done), .a_err(a_err), .b_err(b_err),
        .rdata(rdata),
        .ram_enable(ram_enable), .ram_rw(ram_rw), .ram_size(ram_size),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Byte-addressed little-endian RAM model
    logic [7:0] mem [256];
    logic [7:0] a1, a2, a3;
    assign a1 = ram_addr + 8'd1;
    assign a2 = ram_addr + 8'd2;
    assign a3 = ram_addr + 8'd3;

    always_comb begin
        case (ram_size)
            2'b00:   ram_dout = {24'h0, mem[ram_addr]};
            2'b01:   ram_dout = {16'h0, mem[a1], mem[ram_addr]};
            default: ram_dout = {mem[a3], mem[a2], mem[a1], mem[ram_addr]};
        endcase
    end

    always @(posedge clk) begin
        if (ram_enable && ram_rw) begin
            mem[ram_addr] <= ram_din[7:0];
            if (ram_size != 2'b00) mem[a1] <= ram_din[15:8];
            if (ram_size[1]) begin
                mem[a2] <= ram_din[23:16];
                mem[a3] <= ram_din[31:24];
            end
        end
    end

    typedef struct {
        bit          port_b;
        bit          rw;
        logic [1:0]  size;
        logic [7:0]  addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        bit          port_b;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_access(input vec_t v);
        int          lat, en_cnt;
        bit          got, other, got_err;
        logic [31:0] got_rdata;
        exp_t        e;
        lat = 0; en_cnt = 0; got = 0; other = 0; got_err = 0; got_rdata = '0;
        @(negedge clk);
        sb.push_back('{port_b: v.port_b, err: v.exp_err, rdata: v.exp_rdata});
        if (v.port_b) begin
            b_req = 1'b1; b_rw = v.rw; b_size = v.size; b_addr = v.addr; b_wdata = v.wdata;
        end else begin
            a_req = 1'b1; a_rw = v.rw; a_size = v.size; a_addr = v.addr; a_wdata = v.wdata;
        end
        for (int c = 1; c <= 8 && !got; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ram_enable) begin
                en_cnt++;
                chk("ram_cmd", {ram_rw, ram_size, ram_addr, 21'h0},
                    {v.rw, v.size, v.addr, 21'h0});
                chk("ram_din", ram_din, v.wdata);
            end
            if (v.port_b ? (a_done || a_err) : (b_done || b_err)) other = 1'b1;
            if (v.port_b ? (b_done || b_err) : (a_done || a_err)) begin
                got = 1'b1;
                lat = c;
                got_err = v.port_b ? b_err : a_err;
                got_rdata = rdata;
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL access_timeout actual=none expected=completion addr=%h", v.addr);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            chk("latency", 32'(lat), e.err ? 32'd1 : 32'd2);
            chk("enable_cycles", 32'(en_cnt), e.err ? 32'd0 : 32'd1);
            chk("err_flag", {31'h0, got_err}, {31'h0, e.err});
            chk("rdata", got_rdata, e.rdata);
            chk("other_port_quiet", {31'h0, other}, 32'h0);
        end
    endtask

    task automatic check_reset_state();
        chk("rst_enable", {31'h0, ram_enable}, 32'h0);
        chk("rst_rw", {31'h0, ram_rw}, 32'h0);
        chk("rst_done_err", {28'h0, a_done, b_done, a_err, b_err}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ram_regs", {22'h0, ram_size, ram_addr}, 32'h0);
        chk("rst_ram_din", ram_din, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int          ndone;
        int          done_cyc [4];
        bit          saw_b;
        exp_t        e;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        vecs[0]  = '{1'b0, 1'b1, 2'b10, 8'd12, 32'h33445566, 1'b0, 32'h00000000};
        vecs[1]  = '{1'b1, 1'b0, 2'b10, 8'd12, 32'h00000000, 1'b0, 32'h33445566};
        vecs[2]  = '{1'b0, 1'b1, 2'b10, 8'd0,  32'h11223344, 1'b0, 32'h33445566};
        vecs[3]  = '{1'b0, 1'b1, 2'b00, 8'd2,  32'hAABBCCDD, 1'b0, 32'h33445566};
        vecs[4]  = '{1'b0, 1'b0, 2'b10, 8'd0,  32'h00000000, 1'b0, 32'h11DD3344};
        vecs[5]  = '{1'b1, 1'b1, 2'b01, 8'd6,  32'h1234BEEF, 1'b0, 32'h11DD3344};
        vecs[6]  = '{1'b1, 1'b0, 2'b01, 8'd6,  32'h00000000, 1'b0, 32'h0000BEEF};
        vecs[7]  = '{1'b0, 1'b0, 2'b00, 8'd7,  32'h00000000, 1'b0, 32'h000000BE};
        vecs[8]  = '{1'b0, 1'b0, 2'b00, 8'd2,  32'h00000000, 1'b0, 32'h000000DD};
        vecs[9]  = '{1'b0, 1'b0, 2'b10, 8'd6,  32'h00000000, ALIGN,
                     ALIGN ? 32'h000000DD : 32'h0000BEEF};
        vecs[10] = '{1'b1, 1'b0, 2'b01, 8'd1,  32'h00000000, ALIGN,
                     ALIGN ? 32'h000000DD : 32'h0000DD33};
        vecs[11] = '{1'b0, 1'b1, 2'b10, 8'd5,  32'hCAFEF00D, ALIGN,
                     ALIGN ? 32'h000000DD : 32'h0000DD33};
        vecs[12] = '{1'b0, 1'b0, 2'b00, 8'd5,  32'h00000000, 1'b0,
                     ALIGN ? 32'h00000000 : 32'h0000000D};
        vecs[13] = '{1'b1, 1'b0, 2'b11, 8'd12, 32'h00000000, ALIGN,
                     ALIGN ? 32'h00000000 : 32'h33445566};

        repeat (3) @(negedge clk);
        check_reset_state();
        reset = 1'b0;

        for (int i = 0; i < 14; i++) do_access(vecs[i]);

        // Dual requests straight after reset: A first, then strict alternation
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_state();
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) sb.push_back('{port_b: (k % 2 == 1), err: 1'b0, rdata: 32'h33445566});
        a_req = 1'b1; a_rw = 1'b0; a_size = 2'b10; a_addr = 8'd12;
        b_req = 1'b1; b_rw = 1'b0; b_size = 2'b10; b_addr = 8'd12;
        ndone = 0;
        for (int c = 1; c <= 20 && ndone < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (a_done || b_done) begin
                e = sb.pop_front();
                chk("rr_port", {30'h0, a_done, b_done}, e.port_b ? 32'h1 : 32'h2);
                chk("rr_rdata", rdata, e.rdata);
                done_cyc[ndone] = c;
                ndone++;
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        chk("rr_count", 32'(ndone), 32'd4);
        if (ndone == 4) begin
            for (int k = 0; k < 4; k++) chk("rr_cycle", 32'(done_cyc[k]), 32'(2 + 3 * k));
        end
        while (sb.size() > 0) void'(sb.pop_front());

        // Reset landing in the ACCESS cycle of a B write
        @(negedge clk);
        @(negedge clk);
        b_req = 1'b1; b_rw = 1'b1; b_size = 2'b10; b_addr = 8'd40; b_wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        chk("abort_in_access", {31'h0, ram_enable}, 32'h1);
        reset = 1'b1;
        #1;
        chk("abort_enable_drop", {30'h0, ram_enable, ram_rw}, 32'h0);
        chk("abort_rdata_clear", rdata, 32'h0);
        b_req = 1'b0;
        saw_b = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (b_done || b_err) saw_b = 1'b1;
        end
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (b_done || b_err) saw_b = 1'b1;
        end
        chk("abort_no_b_done", {31'h0, saw_b}, 32'h0);
        do_access('{1'b0, 1'b0, 2'b10, 8'd12, 32'h0, 1'b0, 32'h33445566});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
